// File: rtl/pst_pkg.sv
// Shared types and constants for the theta phase encoder and the sequence predictor.
package pst_pkg;

    localparam int PHASE_W = 8;
    localparam logic [PHASE_W-1:0] PHASE_MAX = 8'd255;

    typedef logic [PHASE_W-1:0] phase_t;

    typedef enum logic {
        WAIT,
        CAPT
    } cap_state_e;

endpackage

// File: rtl/theta_phase_clock.sv
// Free-running theta phase clock: prescaler plus 8-bit phase counter.
// Emits a combinational wrap pulse on the clock that ends a theta cycle.
module theta_phase_clock
    import pst_pkg::*;
#(
    parameter int CLK_PER_PHASE = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    input  logic   phase_rst,
    output phase_t phase_now,
    output logic   wrap
);

    localparam int PRE_W = (CLK_PER_PHASE > 1) ? $clog2(CLK_PER_PHASE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_PER_PHASE - 1);

    logic [PRE_W-1:0] presc_q, presc_d;
    phase_t           phase_q, phase_d;
    logic             presc_max;

    always_comb begin
        presc_max = (presc_q == PRE_MAX);
        // phase_rst and a natural wrap in the same clock collapse into one wrap
        wrap      = en & (phase_rst | (presc_max & (phase_q == PHASE_MAX)));
        presc_d   = presc_q;
        phase_d   = phase_q;
        if (wrap) begin
            presc_d = '0;
            phase_d = '0;
        end else if (en) begin
            if (presc_max) begin
                presc_d = '0;
                phase_d = phase_q + 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            phase_q <= '0;
        end else begin
            presc_q <= presc_d;
            phase_q <= phase_d;
        end
    end

    assign phase_now = phase_q;

endmodule

// File: rtl/theta_phase_encoder.sv
// First-spike phase encoder: stamps the first spike of each theta cycle and
// publishes it on the wrap edge. THETA_ENC_SPIKE_SYNC_EN adds a 2-flop input synchronizer.
//
// state | meaning
// WAIT  | no spike seen yet in the current theta cycle
// CAPT  | first-spike stamp held, counting further spikes
module theta_phase_encoder
    import pst_pkg::*;
#(
    parameter int CLK_PER_PHASE = 4,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             phase_rst,
    input  logic             spike_in,
    output logic             cycle_start,
    output phase_t           actual_phase,
    output logic             fired,
    output logic [CNT_W-1:0] spike_cnt,
    output logic             multi_spike,
    output phase_t           phase_now
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic wrap;
    logic spike_s;

    theta_phase_clock #(
        .CLK_PER_PHASE(CLK_PER_PHASE)
    ) u_clock (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .phase_rst (phase_rst),
        .phase_now (phase_now),
        .wrap      (wrap)
    );

`ifdef THETA_ENC_SPIKE_SYNC_EN
    logic [1:0] sync_q, sync_d;
    assign sync_d  = {sync_q[0], spike_in};
    assign spike_s = sync_q[1];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end
`else
    assign spike_s = spike_in;
`endif

    cap_state_e       state_q, state_d;
    phase_t           stamp_q, stamp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             spike_prev_q, spike_prev_d;
    logic             cycle_start_q, cycle_start_d;
    phase_t           actual_phase_q, actual_phase_d;
    logic             fired_q, fired_d;
    logic [CNT_W-1:0] spike_cnt_q, spike_cnt_d;
    logic             multi_spike_q, multi_spike_d;

    logic             spike_hit;
    logic [CNT_W-1:0] cnt_fin;
    logic             fired_fin;
    phase_t           stamp_fin;

    always_comb begin
        // edge register samples even while disabled so stale edges are dropped
        spike_prev_d   = spike_s;
        spike_hit      = en & spike_s & ~spike_prev_q;
        // count is zero in WAIT, so one increment covers both states
        cnt_fin        = spike_hit ? sat_inc(cnt_q) : cnt_q;
        fired_fin      = (state_q == CAPT) | spike_hit;
        stamp_fin      = ((state_q == WAIT) && spike_hit) ? phase_now : stamp_q;

        state_d        = state_q;
        stamp_d        = stamp_q;
        cnt_d          = cnt_q;
        cycle_start_d  = 1'b0;
        actual_phase_d = actual_phase_q;
        fired_d        = fired_q;
        spike_cnt_d    = spike_cnt_q;
        multi_spike_d  = multi_spike_q;

        if (wrap) begin
            state_d       = WAIT;
            cnt_d         = '0;
            cycle_start_d = 1'b1;
            fired_d       = fired_fin;
            spike_cnt_d   = cnt_fin;
            multi_spike_d = (cnt_fin > CNT_W'(1));
            if (fired_fin) actual_phase_d = stamp_fin;
        end else if (spike_hit) begin
            state_d = CAPT;
            stamp_d = stamp_fin;
            cnt_d   = cnt_fin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= WAIT;
            stamp_q        <= '0;
            cnt_q          <= '0;
            spike_prev_q   <= 1'b0;
            cycle_start_q  <= 1'b0;
            actual_phase_q <= '0;
            fired_q        <= 1'b0;
            spike_cnt_q    <= '0;
            multi_spike_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            stamp_q        <= stamp_d;
            cnt_q          <= cnt_d;
            spike_prev_q   <= spike_prev_d;
            cycle_start_q  <= cycle_start_d;
            actual_phase_q <= actual_phase_d;
            fired_q        <= fired_d;
            spike_cnt_q    <= spike_cnt_d;
            multi_spike_q  <= multi_spike_d;
        end
    end

    assign cycle_start  = cycle_start_q;
    assign actual_phase = actual_phase_q;
    assign fired        = fired_q;
    assign spike_cnt    = spike_cnt_q;
    assign multi_spike  = multi_spike_q;

endmodule

// File: tb/tb_theta_phase_encoder.sv
// Directed bench for theta_phase_encoder with CLK_PER_PHASE=4, CNT_W=4 (1024-clock cycles).
module tb_theta_phase_encoder;

    logic       clk = 1'b0;
    logic       rst_n, en, phase_rst, spike_in;
    logic       cycle_start, fired, multi_spike;
    logic [7:0] actual_phase, phase_now;
    logic [3:0] spike_cnt;

    int n_vec    = 0;
    int n_miscmp = 0;
    int pos      = 0;   // clocks since the last wrap, tracked independently of the DUT

    always #5 clk = ~clk;

    theta_phase_encoder #(
        .CLK_PER_PHASE (4),
        .CNT_W         (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .phase_rst    (phase_rst),
        .spike_in     (spike_in),
        .cycle_start  (cycle_start),
        .actual_phase (actual_phase),
        .fired        (fired),
        .spike_cnt    (spike_cnt),
        .multi_spike  (multi_spike),
        .phase_now    (phase_now)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        bit adv;
        bit pr;
        adv = en && rst_n;
        pr  = en && rst_n && phase_rst;
        @(posedge clk);
        #1;
        if (pr)       pos = 0;
        else if (adv) pos = (pos + 1) % 1024;
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (pos != target && guard < 2100) begin
            step();
            guard++;
        end
        if (pos != target) chk("run_to_bound", pos, target);
    endtask

    task automatic spike_at(input int ph);
        run_to(ph * 4);
        spike_in = 1'b1;
        step();
        spike_in = 1'b0;
    endtask

    // Run to the natural wrap and check the published cycle summary.
    task automatic wrap_check(input string tag, input int ap, input int fd, input int cnt,
                              input int ms, input bit spk_in_wrap, input bit spk_after);
        run_to(1023);
        chk({tag, "_cs_pre"}, cycle_start, 0);
        if (spk_in_wrap) spike_in = 1'b1;
        step();
        spike_in = 1'b0;
        chk({tag, "_cs"}, cycle_start, 1);
        chk({tag, "_ap"}, actual_phase, ap);
        chk({tag, "_fired"}, fired, fd);
        chk({tag, "_cnt"}, spike_cnt, cnt);
        chk({tag, "_multi"}, multi_spike, ms);
        chk({tag, "_phase0"}, phase_now, 0);
        if (spk_after) spike_in = 1'b1;
        step();
        spike_in = 1'b0;
        chk({tag, "_cs_post"}, cycle_start, 0);
        chk({tag, "_ap_hold"}, actual_phase, ap);
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        phase_rst = 1'b0;
        spike_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", cycle_start, 0);
        chk("rst_ap", actual_phase, 0);
        chk("rst_fired", fired, 0);
        chk("rst_cnt", spike_cnt, 0);
        chk("rst_multi", multi_spike, 0);
        chk("rst_phase", phase_now, 0);
        rst_n = 1'b1;
        pos   = 0;

        spike_at(40);
        wrap_check("single", 40, 1, 1, 0, 0, 0);

        spike_at(40);
        spike_at(100);
        spike_at(200);
        wrap_check("three", 40, 1, 3, 1, 0, 0);

        wrap_check("empty", 40, 0, 0, 0, 0, 0);

        wrap_check("wrapspk", 255, 1, 1, 0, 1, 0);
        wrap_check("hold255", 255, 0, 0, 0, 0, 1);
        wrap_check("stamp0", 0, 1, 1, 0, 0, 0);

        spike_at(20);
        run_to(520);
        chk("prst_phase", phase_now, 130);
        phase_rst = 1'b1;
        step();
        phase_rst = 1'b0;
        chk("prst_cs", cycle_start, 1);
        chk("prst_ap", actual_phase, 20);
        chk("prst_fired", fired, 1);
        chk("prst_cnt", spike_cnt, 1);
        chk("prst_phase0", phase_now, 0);
        wrap_check("after_prst", 20, 0, 0, 0, 0, 0);

        run_to(1023);
        phase_rst = 1'b1;
        step();
        phase_rst = 1'b0;
        chk("coinc_cs", cycle_start, 1);
        chk("coinc_fired", fired, 0);
        step();
        chk("coinc_cs_post", cycle_start, 0);

        for (int k = 1; k <= 20; k++) spike_at(k * 10);
        wrap_check("sat", 10, 1, 15, 1, 0, 0);

        run_to(400);
        en       = 1'b0;
        spike_in = 1'b1;
        repeat (10) step();
        chk("en_off_phase", phase_now, 100);
        en = 1'b1;
        step();
        spike_in = 1'b0;
        wrap_check("en_off", 10, 0, 0, 0, 0, 0);

        spike_at(50);
        run_to(600);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_cs", cycle_start, 0);
        chk("mid_rst_ap", actual_phase, 0);
        chk("mid_rst_fired", fired, 0);
        chk("mid_rst_cnt", spike_cnt, 0);
        chk("mid_rst_multi", multi_spike, 0);
        chk("mid_rst_phase", phase_now, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pos   = 0;
        wrap_check("post_rst", 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

// File: doc/theta_phase_encoder.md
# theta_phase_encoder

Upstream stage of the competitive sequence predictor. Runs a free-running theta-cycle phase clock and timestamps the first rising spike edge in each cycle as an 8-bit phase. Once per cycle it presents `actual_phase`, `fired` and `cycle_start`, aligned so the predictor samples them on the `cycle_start` clock edge. It also reports per-cycle spike count and a multi-spike flag for diagnostics.

## Interface
- `CLK_PER_PHASE`, default 4: clocks per phase step, ≥1. Cycle length is 256×CLK_PER_PHASE clocks.
- `CNT_W`, default 4: width of the saturating spike counter.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low; clock `clk`.
- `en` in 1: when low, freezes the prescaler and phase and suppresses capture; outputs hold.
- `phase_rst` in 1: forces an early cycle wrap (external theta reset).
- `spike_in` in 1: spike level; each rising edge is one spike.
- `cycle_start` out 1: one-clock pulse at each cycle wrap.
- `actual_phase` out 8: first-spike phase of the cycle just ended.
- `fired` out 1: high if the ended cycle had ≥1 spike.
- `spike_cnt` out CNT_W: spikes in the ended cycle, saturating.
- `multi_spike` out 1: high if the ended cycle had ≥2 spikes.
- `phase_now` out 8: current phase counter.

## Operation
- Prescaler counts 0..CLK_PER_PHASE-1 while `en`=1. `phase_now` increments when the prescaler is at its maximum.
- Wrap event = `en` & (`phase_rst` | (prescaler max & `phase_now`==255)). On a wrap, prescaler and `phase_now` go to 0.
- A spike is the rising edge of `spike_in` against the previous sample. It is stamped with the `phase_now` register value in the detection clock.
- Capture FSM:
  - WAIT: first spike → store stamp, count=1, go to CAPT.
  - CAPT: further spikes increment the count (saturating at 2^CNT_W-1). The stamp is unchanged.
  - A wrap from either state → WAIT, count cleared.
- On the wrap edge, registered outputs update together:
  - `cycle_start`=1.
  - `fired` = (state==CAPT or a spike in this same clock).
  - `actual_phase` = the stamp if fired, otherwise the previous value is held.
  - `spike_cnt` = final count.
  - `multi_spike` = (count ≥ 2).
- A spike in the wrap clock belongs to the ending cycle (stamp = 255, or the current phase for a `phase_rst` wrap). A spike in the clock after the wrap has stamp 0 and belongs to the new cycle.
- `phase_rst` coinciding with a natural wrap produces one wrap only.
- `en`=0: no detection, no wrap. The edge-detect register keeps sampling, so an edge that occurs while disabled is not counted later.
- Reset mid-cycle: everything goes to its reset value immediately and the FSM returns to WAIT. A partial cycle is discarded, with no `cycle_start` for it.

## Timing
- Reset values:
  - `cycle_start`, `actual_phase`, `fired`, `spike_cnt`, `multi_spike`, `phase_now`: all 0.
  - FSM: WAIT.
- First `cycle_start` arrives 256×CLK_PER_PHASE clocks after reset release, with `en` held high.
- `cycle_start` is high for exactly one clock. The other outputs change only on wrap edges and are stable for the whole following cycle.
- Spike-to-stamp latency: 1 clock (edge-detect register). Stamps are not latency-compensated.

## Configuration
- `THETA_ENC_SPIKE_SYNC_EN`:
  - Defined: `spike_in` passes through a 2-flop synchronizer before edge detection. Detection latency becomes 3 clocks, and a spike stamps the phase present at detection.
  - Undefined: `spike_in` is assumed synchronous to `clk`, with a single edge-detect register.

## Structure
- Shared package `pst_pkg`:
  - `PHASE_W`=8 and `PHASE_MAX`=8'd255.
  - Capture state enum {WAIT, CAPT}.
  - Phase typedef shared with the predictor.
- Sub-module `theta_phase_clock`: holds the prescaler and phase counter. Inputs `en` and `phase_rst`; outputs `phase_now` and a `wrap` pulse.
- The top level contains edge detection, the FSM and the output registers.

## Test plan
All scenarios use CLK_PER_PHASE=4 and CNT_W=4.
- Single spike at phase 40 → next `cycle_start`: `actual_phase`=40, `fired`=1, `spike_cnt`=1, `multi_spike`=0.
- Spikes at phases 40, 100, 200 → `actual_phase`=40, `spike_cnt`=3, `multi_spike`=1.
- Cycle with no spike after a cycle that captured 40 → `fired`=0, `actual_phase` holds 40, `spike_cnt`=0.
- Spike edge in the wrap clock (phase 255) → counted in the ending cycle with `actual_phase`=255. A spike in the next clock → stamp 0 in the following cycle.
- Spike at 20, then `phase_rst` at phase 130 → `cycle_start` on the next edge with `actual_phase`=20. The next natural wrap comes 1024 clocks later.
- 20 spikes in one cycle → `spike_cnt`=15. Then `rst_n` pulsed mid-cycle → all outputs 0 and no `cycle_start` until 1024 clocks after release.
